frame_stream_switch: RTL and testbench
======================================

FRAME_STREAM_SWITCH -- requirements
Module: frame_stream_switch

Interface
REQ-001 The module SHALL have parameter NUM_PIXELS, default 320*240, giving the pixels per frame.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 12, giving the pixel width.
REQ-003 The module SHALL have parameter NUM_SOURCES, default 2 (legal 2..4), giving the number of input streams.
REQ-004 clk  input  1  sole clock, all logic on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-low (asserted when 0).
REQ-006 sel  input  $clog2(NUM_SOURCES)  requested source index.
REQ-007 src_data  input  NUM_SOURCES x DATA_WIDTH  per-source pixel.
REQ-008 src_valid, src_startofpacket, src_endofpacket  input  NUM_SOURCES each  per-source stream flags.
REQ-009 src_ready  output  NUM_SOURCES  per-source ready.
REQ-010 data  output  DATA_WIDTH  switched pixel.
REQ-011 valid, startofpacket, endofpacket  output  1 each  switched stream flags.
REQ-012 ready  input  1  downstream ready.
REQ-013 active_src  output  $clog2(NUM_SOURCES)  source currently owning the output.
REQ-014 frame_done  output  1  one-cycle pulse on an accepted endofpacket beat.
REQ-015 length_error  output  1  one-cycle pulse on a malformed frame.

Function
REQ-016 Data path SHALL be combinational, zero latency: data/flags = src_*[active_src]; src_ready[active_src] = ready when forwarding.
REQ-017 FSM states SHALL be SEARCH and STREAM; a handshake is valid&ready on the output, or src_valid&src_ready on a discarded beat.
REQ-018 In SEARCH, active_src SHALL load sel every cycle (registered, so it takes effect the next cycle).
REQ-019 In SEARCH, non-SOP beats of active_src SHALL be discarded: valid=0, src_ready[active_src]=1.
REQ-020 In SEARCH, an SOP beat of active_src SHALL be forwarded; on its handshake the FSM SHALL enter STREAM with pixel count=1.
REQ-021 In STREAM, active_src SHALL be frozen; sel changes SHALL take effect only after the frame ends.
REQ-022 Each accepted beat in STREAM SHALL increment the pixel counter (width $clog2(NUM_PIXELS+1), no wrap).
REQ-023 An accepted EOP beat whose 0-based index is NUM_PIXELS-1 SHALL pulse frame_done and return the FSM to SEARCH.
REQ-024 An accepted EOP beat at any other index SHALL pulse frame_done and length_error and return to SEARCH.
REQ-025 An accepted beat at index NUM_PIXELS-1 without EOP SHALL pulse length_error; the FSM SHALL return to SEARCH and the remaining beats are discarded there.
REQ-026 An accepted SOP beat in STREAM SHALL pulse length_error and restart the frame: count=1, FSM stays in STREAM.
REQ-027 An accepted beat carrying both SOP and EOP in SEARCH SHALL pulse frame_done (and length_error unless NUM_PIXELS=1) and the FSM SHALL stay in SEARCH.
REQ-028 The output stream SHALL never stall on its own: valid SHALL drop only when the active source's valid drops or while discarding.

Reset
REQ-029 While reset=0: state=SEARCH, active_src=0, count=0, valid=0, frame_done=0, length_error=0, all src_ready=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no frame_done; after release the block SHALL resynchronise on the next SOP of sel.

Configuration
REQ-031 Macro FRAME_SWITCH_DRAIN_EN defined: non-active sources SHALL have src_ready=1 (free-running sources are drained, their beats discarded).
REQ-032 FRAME_SWITCH_DRAIN_EN undefined: non-active sources SHALL have src_ready=0 (stalled, resume in place).

Structure
REQ-033 A package frame_stream_pkg SHALL hold the state enum type, the default NUM_PIXELS/DATA_WIDTH constants and the pixel-count width function.
REQ-034 The frame-length checker (counter plus REQ-022..026 error logic) SHALL be a sub-module frame_length_checker; the FSM and muxing stay in the top.

Verification (bench NUM_PIXELS=16, NUM_SOURCES=2, DATA_WIDTH=12)
REQ-035 Test 1: sel=0, source 0 sends a 16-beat frame, ready=1 -> 16 output beats identical to input, SOP on beat 0, EOP on beat 15, one frame_done, no length_error.
REQ-036 Test 2: sel switched 0->1 at beat 5 -> frame from source 0 completes all 16 beats, then active_src=1 and the next output SOP comes from source 1.
REQ-037 Test 3: after sel=1 in SEARCH, source 1 sends beats 7..15 of a frame, then a new frame -> beats 7..15 are discarded (valid=0), output starts at the SOP.
REQ-038 Test 4: EOP at beat 9 -> frame_done and length_error at beat 9; 17-beat frame -> length_error at beat 15 and beat 16 discarded.
REQ-039 Test 5: ready toggled 1,0,0,1 randomly over the frame -> no beat lost or duplicated, count and EOP still correct.
REQ-040 Test 6: reset=0 at beat 8 for 2 cycles -> all outputs 0, no frame_done; after release, resync on the next SOP; run once with FRAME_SWITCH_DRAIN_EN defined (src_ready[1]=1) and once without (src_ready[1]=0).

Source files
------------

// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame stream switch.
package frame_stream_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        STREAM = 1'b1
    } fss_state_e;

    localparam int DEFAULT_NUM_PIXELS = 320 * 240;
    localparam int DEFAULT_DATA_WIDTH = 12;

    function automatic int pixel_count_width(input int num_pixels);
        return $clog2(num_pixels + 1);
    endfunction

endpackage

// File: rtl/frame_stream_switch_checker.sv
// frame_length_checker: pixel counter and frame-length error detection for accepted beats.
module frame_length_checker
    import frame_stream_pkg::*;
#(
    parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS
) (
    input  logic clk,
    input  logic reset,
    input  logic in_search,
    input  logic beat_acc,
    input  logic beat_sop,
    input  logic beat_eop,
    output logic frame_done,
    output logic length_error,
    output logic to_search
);

    localparam int CW = pixel_count_width(NUM_PIXELS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIXELS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] beat_idx_s;
    logic          sop_err_s;

    // An SOP beat always restarts indexing at 0, even mid-frame.
    always_comb begin
        frame_done   = 1'b0;
        length_error = 1'b0;
        to_search    = in_search;
        count_d      = count_q;
        sop_err_s    = beat_sop & ~in_search;
        beat_idx_s   = beat_sop ? {CW{1'b0}} : count_q;
        if (beat_acc) begin
            if (beat_eop) begin
                frame_done   = 1'b1;
                length_error = sop_err_s | (beat_idx_s != LAST_IDX);
                to_search    = 1'b1;
                count_d      = {CW{1'b0}};
            end else if (beat_idx_s == LAST_IDX) begin
                length_error = 1'b1;
                to_search    = 1'b1;
                count_d      = {CW{1'b0}};
            end else begin
                length_error = sop_err_s;
                to_search    = 1'b0;
                count_d      = beat_idx_s + CW'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Pixel counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_stream_switch.sv
// Frame-aligned N:1 stream switch; source changes only take effect between frames.
// Define FRAME_SWITCH_DRAIN_EN to drain (rather than stall) non-active sources.
module frame_stream_switch
    import frame_stream_pkg::*;
#(
    parameter int NUM_PIXELS  = DEFAULT_NUM_PIXELS,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_SOURCES = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [$clog2(NUM_SOURCES)-1:0]         sel,
    input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]                 src_valid,
    input  logic [NUM_SOURCES-1:0]                 src_startofpacket,
    input  logic [NUM_SOURCES-1:0]                 src_endofpacket,
    output logic [NUM_SOURCES-1:0]                 src_ready,
    output logic [DATA_WIDTH-1:0]                  data,
    output logic                                   valid,
    output logic                                   startofpacket,
    output logic                                   endofpacket,
    input  logic                                   ready,
    output logic [$clog2(NUM_SOURCES)-1:0]         active_src,
    output logic                                   frame_done,
    output logic                                   length_error
);

    localparam int SW = $clog2(NUM_SOURCES);
`ifdef FRAME_SWITCH_DRAIN_EN
    localparam logic IDLE_READY = 1'b1;
`else
    localparam logic IDLE_READY = 1'b0;
`endif

    fss_state_e    state_q;
    fss_state_e    state_d;
    logic [SW-1:0] active_src_q;
    logic [SW-1:0] active_src_d;
    logic          src_valid_s;
    logic          src_sop_s;
    logic          src_eop_s;
    logic          fwd_s;
    logic          acc_s;
    logic          to_search_s;

    // Zero-latency mux; in SEARCH only SOP beats pass, the rest are swallowed.
    always_comb begin
        src_valid_s   = src_valid[active_src_q];
        src_sop_s     = src_startofpacket[active_src_q];
        src_eop_s     = src_endofpacket[active_src_q];
        fwd_s         = (state_q == STREAM) | src_sop_s;
        valid         = reset & src_valid_s & fwd_s;
        data          = reset ? src_data[active_src_q] : {DATA_WIDTH{1'b0}};
        startofpacket = valid & src_sop_s;
        endofpacket   = valid & src_eop_s;
        acc_s         = valid & ready;
        src_ready     = {NUM_SOURCES{1'b0}};
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!reset) begin
                src_ready[i] = 1'b0;
            end else if (SW'(i) == active_src_q) begin
                src_ready[i] = fwd_s ? ready : 1'b1;
            end else begin
                src_ready[i] = IDLE_READY;
            end
        end
    end

    frame_length_checker #(
        .NUM_PIXELS (NUM_PIXELS)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .in_search    (state_q == SEARCH),
        .beat_acc     (acc_s),
        .beat_sop     (src_sop_s),
        .beat_eop     (src_eop_s),
        .frame_done   (frame_done),
        .length_error (length_error),
        .to_search    (to_search_s)
    );

    // Source selection tracks sel in SEARCH but is held from the SOP handshake onward.
    always_comb begin
        state_d      = state_q;
        active_src_d = active_src_q;
        case (state_q)
            SEARCH: begin
                if (acc_s && !to_search_s) begin
                    state_d      = STREAM;
                    active_src_d = active_src_q;
                end else begin
                    state_d      = SEARCH;
                    active_src_d = sel;
                end
            end
            STREAM: begin
                if (acc_s && to_search_s) begin
                    state_d = SEARCH;
                end else begin
                    state_d = STREAM;
                end
                active_src_d = active_src_q;
            end
            default: begin
                state_d      = SEARCH;
                active_src_d = {SW{1'b0}};
            end
        endcase
    end

    // FSM state and owning-source registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SEARCH;
            active_src_q <= {SW{1'b0}};
        end else begin
            state_q      <= state_d;
            active_src_q <= active_src_d;
        end
    end

    assign active_src = active_src_q;

endmodule

// File: tb/tb_frame_stream_switch.sv
// Directed self-checking bench for frame_stream_switch (NUM_PIXELS=16, 2 sources).
module tb_frame_stream_switch;

    localparam int NP = 16;
    localparam int NS = 2;
    localparam int DW = 12;
`ifdef FRAME_SWITCH_DRAIN_EN
    localparam logic IDLE_RDY = 1'b1;
`else
    localparam logic IDLE_RDY = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   sel;
    logic [NS-1:0][DW-1:0]  src_data;
    logic [NS-1:0]          src_valid;
    logic [NS-1:0]          src_sop;
    logic [NS-1:0]          src_eop;
    logic [NS-1:0]          src_ready;
    logic [DW-1:0]          data;
    logic                   valid;
    logic                   sop;
    logic                   eop;
    logic                   ready;
    logic                   active_src;
    logic                   frame_done;
    logic                   length_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_stream_switch #(
        .NUM_PIXELS  (NP),
        .DATA_WIDTH  (DW),
        .NUM_SOURCES (NS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sel               (sel),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_startofpacket (src_sop),
        .src_endofpacket   (src_eop),
        .src_ready         (src_ready),
        .data              (data),
        .valid             (valid),
        .startofpacket     (sop),
        .endofpacket       (eop),
        .ready             (ready),
        .active_src        (active_src),
        .frame_done        (frame_done),
        .length_error      (length_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        src_valid = '0;
        src_sop   = '0;
        src_eop   = '0;
        #3;
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);
        cyc();
    endtask

    // Present one beat from source s; pixel value encodes source and beat index.
    task automatic beat(input int s, input int k, input logic sp, input logic ep,
                        input logic exp_v, input logic exp_fd, input logic exp_le);
        src_valid    = '0;
        src_sop      = '0;
        src_eop      = '0;
        src_valid[s] = 1'b1;
        src_sop[s]   = sp;
        src_eop[s]   = ep;
        src_data[s]  = DW'(s * 256 + k);
        #3;
        chk("valid", 32'(valid), 32'(exp_v));
        if (exp_v) begin
            chk("data", 32'(data), 32'(s * 256 + k));
            chk("sop", 32'(sop), 32'(sp));
            chk("eop", 32'(eop), 32'(ep));
        end
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("length_error", 32'(length_error), 32'(exp_le));
        chk("src_ready_active", 32'(src_ready[s]),
            32'(reset ? (exp_v ? ready : 1'b1) : 1'b0));
        chk("src_ready_other", 32'(src_ready[1-s]), 32'(reset ? IDLE_RDY : 1'b0));
        cyc();
    endtask

    initial begin
        int            k;
        logic [15:0]   rpat;

        reset     = 1'b0;
        sel       = 1'b0;
        ready     = 1'b1;
        src_data  = '0;
        src_valid = '0;
        src_sop   = '0;
        src_eop   = '0;
        cyc();
        cyc();

        // Reset state, with a live SOP on source 0 that must not leak through
        src_valid[0] = 1'b1;
        src_sop[0]   = 1'b1;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sop", 32'(sop), 32'd0);
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_length_error", 32'(length_error), 32'd0);
        chk("rst_active_src", 32'(active_src), 32'd0);
        src_valid = '0;
        src_sop   = '0;
        reset     = 1'b1;
        cyc();

        // Test 1: clean 16-beat frame from source 0
        for (int i = 0; i < NP; i++) beat(0, i, i == 0, i == NP - 1, 1'b1, i == NP - 1, 1'b0);
        chk("t1_active", 32'(active_src), 32'd0);

        // Test 2: sel flips mid-frame, ownership changes only after EOP
        for (int i = 0; i < NP; i++) begin
            if (i == 5) sel = 1'b1;
            chk("t2_active_frozen", 32'(active_src), 32'd0);
            beat(0, i, i == 0, i == NP - 1, 1'b1, i == NP - 1, 1'b0);
        end
        idle();
        chk("t2_active_switched", 32'(active_src), 32'd1);
        for (int i = 0; i < NP; i++) beat(1, i, i == 0, i == NP - 1, 1'b1, i == NP - 1, 1'b0);

        // Test 3: tail of a frame is discarded until the next SOP
        for (int i = 7; i < NP; i++) beat(1, i, 1'b0, i == NP - 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NP; i++) beat(1, i, i == 0, i == NP - 1, 1'b1, i == NP - 1, 1'b0);

        // Test 4a: short frame, EOP at index 9
        for (int i = 0; i < 10; i++) beat(1, i, i == 0, i == 9, 1'b1, i == 9, i == 9);
        // Test 4b: 17-beat frame, error at index 15, index 16 discarded
        for (int i = 0; i < NP; i++) beat(1, i, i == 0, 1'b0, 1'b1, 1'b0, i == NP - 1);
        beat(1, NP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Test 5: backpressure pattern, source holds each beat until accepted
        rpat = 16'b0110_1001_1001_0011;
        k    = 0;
        for (int c = 0; c < 64 && k < NP; c++) begin
            ready        = rpat[c % 16];
            src_valid    = 2'b10;
            src_sop      = '0;
            src_eop      = '0;
            src_sop[1]   = (k == 0);
            src_eop[1]   = (k == NP - 1);
            src_data[1]  = DW'(256 + k);
            #3;
            chk("t5_valid", 32'(valid), 32'd1);
            chk("t5_data", 32'(data), 32'(256 + k));
            chk("t5_eop", 32'(eop), 32'(k == NP - 1));
            chk("t5_src_ready", 32'(src_ready[1]), 32'(ready));
            chk("t5_frame_done", 32'(frame_done), 32'(ready && k == NP - 1));
            chk("t5_length_error", 32'(length_error), 32'd0);
            if (ready) k++;
            cyc();
        end
        ready = 1'b1;
        chk("t5_beats_accepted", 32'(k), 32'(NP));

        // Test 6: reset in the middle of a source-0 frame
        sel = 1'b0;
        idle();
        chk("t6_active", 32'(active_src), 32'd0);
        for (int i = 0; i < 8; i++) beat(0, i, i == 0, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        beat(0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(0, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        chk("t6_active_after_reset", 32'(active_src), 32'd0);
        for (int i = 10; i < NP; i++) beat(0, i, 1'b0, i == NP - 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NP; i++) beat(0, i, i == 0, i == NP - 1, 1'b1, i == NP - 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
